controlador_ula_rr: RTL



---
 rtl/controlador_ula_rr_if.sv | 60 ++++++
 rtl/controlador_ula_rr.sv | 96 +++++++++
 2 files changed

// File: rtl/controlador_ula_rr_if.sv
// -----------------------------------------------------------------------------
// controlador_ula_rr_if
// Bundle of every signal between the round-robin ALU controller, its two
// requesters, the shared ALU result mux and the response consumer.
//
// Handshake semantics:
//   Command side:  requester i raises req_valid[i] and holds its op/a/b stable.
//                  The command is taken at the rising edge that ends a cycle in
//                  which req_ready[i] is high. req_ready is combinational and
//                  never has both bits set.
//   Response side: rsp_valid, rsp_id and rsp_data stay stable until a rising
//                  edge samples rsp_ready high. That edge completes the transfer.
//
// Signals:
//   req_valid[1:0]  requester -> ctrl   command present, one bit per requester
//   req_ready[1:0]  ctrl -> requester   command accepted this cycle
//   reqN_op[2:0]    requester -> ctrl   operation (ALU mux select)
//   reqN_a/b[7:0]   requester -> ctrl   operands
//   alu_a/b[7:0]    ctrl -> ALU         registered operands
//   alu_sel[2:0]    ctrl -> ALU         registered mux select
//   alu_result[7:0] ALU -> ctrl         combinational mux output
//   rsp_valid       ctrl -> consumer    response available
//   rsp_id          ctrl -> consumer    owning requester index
//   rsp_data[7:0]   ctrl -> consumer    captured ALU result
//   rsp_ready       consumer -> ctrl    response accepted
//   busy            ctrl -> any         controller not idle
// -----------------------------------------------------------------------------
interface controlador_ula_rr_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [2:0] req0_op;
    logic [2:0] req1_op;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_ready;
    logic       busy;

    // Environment side: requesters, ALU mux and response consumer.
    modport master (
        output req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
        output alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, busy
    );

    // Controller side.
    modport slave (
        input  req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
        input  alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/controlador_ula_rr.sv
// -----------------------------------------------------------------------------
// controlador_ula_rr
// Shares one 8-bit ALU (8-way result mux) between two requesters using
// round-robin arbitration. Flow: IDLE (grant) -> EXEC (one cycle, ALU settles)
// -> RESP (hold result until consumer takes it) -> IDLE.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        controlador_ula_rr_if.slave (requesters, ALU, response)
//   dbg_state  current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// -----------------------------------------------------------------------------
module controlador_ula_rr (
    input  logic                       clk,
    input  logic                       rst_n,
    controlador_ula_rr_if.slave        bus,
    output logic [1:0]                 dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       prio;     // requester that wins when both are valid
    logic       id_q;     // index of the in-flight transaction
    logic [1:0] grant;    // one-hot arbitration result, valid only in IDLE

    always_comb begin
        grant = 2'b00;
        if (bus.req_valid == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end else if (bus.req_valid[0]) begin
            grant = 2'b01;
        end else if (bus.req_valid[1]) begin
            grant = 2'b10;
        end
    end

    // Gated by rst_n so the acceptance strobe drops immediately on reset,
    // even though the state register already reads IDLE then.
    assign bus.req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            prio          <= 1'b0;
            id_q          <= 1'b0;
            bus.alu_sel   <= 3'd0;
            bus.alu_a     <= 8'd0;
            bus.alu_b     <= 8'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_data  <= 8'd0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        // Snapshot the winner so later requester activity
                        // cannot disturb the operation in flight.
                        id_q        <= grant[1];
                        prio        <= ~grant[1];
                        bus.alu_sel <= grant[1] ? bus.req1_op : bus.req0_op;
                        bus.alu_a   <= grant[1] ? bus.req1_a  : bus.req0_a;
                        bus.alu_b   <= grant[1] ? bus.req1_b  : bus.req0_b;
                        bus.busy    <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    bus.rsp_data  <= bus.alu_result;
                    bus.rsp_id    <= id_q;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
